crc_checker: RTL

//  Receive-side CRC checker/stripper on the USB RX serial path. It sits after the bit unstuffer and takes de-stuffed

---
 rtl/crc_checker.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/crc_checker.sv
// Receive-side USB CRC checker/stripper: passes SYNC+PID through, checks the CRC5/CRC16 residue
// and holds back the trailing CRC field in a delay line, so only header and payload bits are emitted.
module crc_checker #(
    parameter int HDR_BITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_in,
    input  logic       in_valid,
    input  logic       sop,
    input  logic       eop,
    input  logic [1:0] pkt_in,
    output logic       s_out,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic       crc_ok,
    output logic       crc_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PK_NONE   = 2'b00,
        PK_TOKEN  = 2'b01,
        PK_HSHAKE = 2'b10,
        PK_DATA   = 2'b11
    } pkt_t;

    localparam logic [4:0]  POLY5    = 5'b00101;
    localparam logic [15:0] POLY16   = 16'h8005;
    localparam logic [4:0]  RES5     = 5'b01100;
    localparam logic [15:0] RES16    = 16'h800D;
    localparam logic [6:0]  HDR_LEN  = 7'(HDR_BITS);
    localparam logic [6:0]  HDR_MAX  = 7'd127;
    localparam logic [9:0]  BODY_MAX = 10'd1023;
    localparam logic [9:0]  TOKEN_BODY = 10'd16;

    state_t      state;
    state_t      state_nxt;
    state_t      eff_state;
    pkt_t        pkt;
    pkt_t        eff_pkt;
    logic [6:0]  hdr_cnt;
    logic [6:0]  eff_hdr_cnt;
    logic [6:0]  hdr_cnt_inc;
    logic [6:0]  hdr_fin;
    logic        first_pend;
    logic        eff_first;
    logic [9:0]  body_cnt;
    logic [9:0]  body_cnt_inc;
    logic [9:0]  body_fin;
    logic [4:0]  fill;
    logic [4:0]  crc_w;
    logic [15:0] dline;
    logic [15:0] crc;
    logic [15:0] crc_upd;
    logic [15:0] crc_fin;
    logic [4:0]  crc5_upd;
    logic        fb5;
    logic        fb16;
    logic        start;
    logic        is_data;
    logic        is_token;
    logic        dline_full;
    logic        dline_oldest;
    logic        residue_ok;
    logic        body_pass;
    logic        hdr_pass;

    // A sop with a valid class restarts the packet on this very bit, whatever state we are in;
    // everything below works on these "effective" values so the restart and the bit share one path.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        start       = sop && (pkt_in != 2'b00);
        eff_state   = state;
        eff_pkt     = pkt;
        eff_hdr_cnt = hdr_cnt;
        eff_first   = first_pend;
        if (sop) begin
            if (start) begin
                eff_state   = HDR;
                eff_pkt     = pkt_t'(pkt_in);
                eff_hdr_cnt = 7'd0;
                eff_first   = 1'b1;
            end else begin
                eff_state   = IDLE;
            end
        end
    end

    always_comb begin
        is_data  = (eff_pkt == PK_DATA);
        is_token = (eff_pkt == PK_TOKEN);
        crc_w    = is_data ? 5'd16 : 5'd5;

        fb16     = s_in ^ crc[15];
        fb5      = s_in ^ crc[4];
        crc5_upd = {crc[3:0], 1'b0} ^ (fb5 ? POLY5 : 5'd0);
        crc_upd  = is_data ? ({crc[14:0], 1'b0} ^ (fb16 ? POLY16 : 16'd0))
                           : {11'd0, crc5_upd};
        crc_fin  = in_valid ? crc_upd : crc;

        hdr_cnt_inc  = (eff_hdr_cnt == HDR_MAX) ? HDR_MAX : eff_hdr_cnt + 7'd1;
        hdr_fin      = in_valid ? hdr_cnt_inc : eff_hdr_cnt;
        body_cnt_inc = (body_cnt == BODY_MAX) ? BODY_MAX : body_cnt + 10'd1;
        body_fin     = in_valid ? body_cnt_inc : body_cnt;

        dline_full   = (fill == crc_w);
        dline_oldest = is_data ? dline[15] : dline[4];

        residue_ok = is_data ? (crc_fin == RES16) : (crc_fin[4:0] == RES5);
        body_pass  = (body_fin >= {5'd0, crc_w})
                     && (!is_token || (body_fin == TOKEN_BODY))
                     && residue_ok;
        hdr_pass   = (hdr_fin == HDR_LEN);
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (eff_state)
            IDLE: state_nxt = IDLE;
            HDR: begin
                if (eop)
                    state_nxt = DONE;
                else if (in_valid && (hdr_cnt_inc == HDR_LEN) && (eff_pkt != PK_HSHAKE))
                    state_nxt = BODY;
                else
                    state_nxt = HDR;
            end
            BODY: state_nxt = eop ? DONE : BODY;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the reset is synchronous and all state uses non-blocking assignments, so every
    // register here updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pkt        <= PK_NONE;
            hdr_cnt    <= 7'd0;
            body_cnt   <= 10'd0;
            fill       <= 5'd0;
            dline      <= 16'd0;
            crc        <= 16'hFFFF;
            first_pend <= 1'b0;
            s_out      <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            s_out     <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;

            if (start) begin
                pkt        <= pkt_t'(pkt_in);
                hdr_cnt    <= 7'd0;
                first_pend <= 1'b1;
            end

            unique case (eff_state)
                HDR: begin
                    if (in_valid) begin
                        s_out      <= s_in;
                        out_valid  <= 1'b1;
                        out_sop    <= eff_first;
                        first_pend <= 1'b0;
                        hdr_cnt    <= hdr_cnt_inc;
                    end
                    if (eop) begin
                        out_eop <= 1'b1;
                        if (eff_pkt == PK_HSHAKE) begin
                            crc_ok  <= hdr_pass;
                            crc_err <= !hdr_pass;
                        end else begin
                            crc_err <= 1'b1;
                        end
                    end else if (state_nxt == BODY) begin
                        crc      <= 16'hFFFF;
                        fill     <= 5'd0;
                        body_cnt <= 10'd0;
                        dline    <= 16'd0;
                    end
                end
                BODY: begin
                    if (in_valid) begin
                        crc      <= crc_upd;
                        body_cnt <= body_cnt_inc;
                        dline    <= {dline[14:0], s_in};
                        // Once the line holds a full CRC's worth of bits, the oldest one is payload.
                        if (dline_full) begin
                            s_out      <= dline_oldest;
                            out_valid  <= 1'b1;
                            out_sop    <= first_pend;
                            first_pend <= 1'b0;
                        end else begin
                            fill <= fill + 5'd1;
                        end
                    end
                    if (eop) begin
                        out_eop <= 1'b1;
                        crc_ok  <= body_pass;
                        crc_err <= !body_pass;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
